// File: rtl/wm_blend_ctrl_pkg.sv
// Shared widths, rounding bias and FSM encoding for the watermark blend controller.
package wm_blend_ctrl_pkg;

    localparam int unsigned PIX_W      = 8;
    localparam int unsigned PROD_W     = 16;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned ROUND_BIAS = 128;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StMulImg = 2'd1,
        StMulWm  = 2'd2,
        StHold   = 2'd3
    } state_e;

    // 255 - w for an 8-bit weight is a plain bitwise inversion.
    function automatic logic [PIX_W-1:0] inv_weight(input logic [PIX_W-1:0] w);
        return ~w;
    endfunction

endpackage

// File: rtl/mult8x8.sv
// Combinational unsigned 8x8 -> 16 multiplier shared by both blend products.
module mult8x8
    import wm_blend_ctrl_pkg::*;
(
    input  logic [PIX_W-1:0]  a_i,
    input  logic [PIX_W-1:0]  b_i,
    output logic [PROD_W-1:0] p_o
);

    assign p_o = PROD_W'(a_i) * PROD_W'(b_i);

endmodule

// File: rtl/wm_blend_ctrl.sv
// Alpha blend of an image pixel with a watermark pixel, computed over two cycles
// on a single shared multiplier, with a valid/ready handshake on both sides.
module wm_blend_ctrl
    import wm_blend_ctrl_pkg::*;
#(
    parameter int unsigned ROUND = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [PIX_W-1:0] img_pix_i,
    input  logic [PIX_W-1:0] wm_pix_i,
    input  logic [PIX_W-1:0] cfg_alpha_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [PIX_W-1:0] out_pix_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] pix_count_o
);

    localparam logic [PROD_W-1:0] Bias = (ROUND != 0) ? PROD_W'(ROUND_BIAS) : '0;

    state_e             state_q, state_d;
    logic [PIX_W-1:0]   img_q, img_d;
    logic [PIX_W-1:0]   wm_q, wm_d;
    logic [PIX_W-1:0]   alpha_q, alpha_d;
    logic [PROD_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PIX_W-1:0]   mul_a, mul_b;
    logic [PROD_W-1:0]  mul_p;

    mult8x8 u_mult (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    // Operand mux: the watermark pass uses the complementary weight.
    always_comb begin
        mul_a = img_q;
        mul_b = alpha_q;
        if (state_q == StMulWm) begin
            mul_a = wm_q;
            mul_b = inv_weight(alpha_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        img_d       = img_q;
        wm_d        = wm_q;
        alpha_d     = alpha_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    img_d   = img_pix_i;
                    wm_d    = wm_pix_i;
                    alpha_d = cfg_alpha_i;
                    state_d = StMulImg;
                end
            end
            StMulImg: begin
                acc_d   = mul_p + Bias;
                state_d = StMulWm;
            end
            StMulWm: begin
                // Worst case 255*255 + 128 = 65153 still fits in 16 bits.
                acc_d   = acc_q + mul_p;
                state_d = StHold;
            end
            StHold: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            img_q   <= '0;
            wm_q    <= '0;
            alpha_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            img_q   <= img_d;
            wm_q    <= wm_d;
            alpha_q <= alpha_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_pix_o   = acc_q[PROD_W-1:PROD_W-PIX_W];
    assign busy_o      = (state_q != StIdle);
    assign pix_count_o = cnt_q;

endmodule

// File: tb/tb_wm_blend_ctrl.sv
// Directed bench for wm_blend_ctrl: a rounding instance and a truncating instance
// run in lockstep on the same inputs.
module tb_wm_blend_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  img_pix, wm_pix, cfg_alpha;

    logic        in_ready, out_valid, busy;
    logic [7:0]  out_pix;
    logic [15:0] pix_count;
    logic        in_ready_t, out_valid_t, busy_t;
    logic [7:0]  out_pix_t;
    logic [15:0] pix_count_t;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_cnt   = '0;
    logic [15:0] exp_cnt_t = '0;

    // Back-to-back stimulus: accepts land on steps 0 and 4 only.
    logic [7:0] bb_a   [8] = '{8'd255, 8'd9, 8'd9, 8'd9, 8'd0,   8'd9, 8'd9, 8'd9};
    logic [7:0] bb_img [8] = '{8'd200, 8'd1, 8'd2, 8'd3, 8'd10,  8'd4, 8'd5, 8'd6};
    logic [7:0] bb_wm  [8] = '{8'd50,  8'd7, 8'd7, 8'd7, 8'd255, 8'd7, 8'd7, 8'd7};
    logic       bb_rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       bb_ov  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] bb_px  [8] = '{8'd0, 8'd0, 8'd0, 8'd199, 8'd0, 8'd0, 8'd0, 8'd254};

    always #5 clk = ~clk;

    wm_blend_ctrl #(.ROUND(1)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .img_pix_i   (img_pix),
        .wm_pix_i    (wm_pix),
        .cfg_alpha_i (cfg_alpha),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_pix_o   (out_pix),
        .busy_o      (busy),
        .pix_count_o (pix_count)
    );

    wm_blend_ctrl #(.ROUND(0)) dut_t (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_t),
        .img_pix_i   (img_pix),
        .wm_pix_i    (wm_pix),
        .cfg_alpha_i (cfg_alpha),
        .out_valid_o (out_valid_t),
        .out_ready_i (out_ready),
        .out_pix_o   (out_pix_t),
        .busy_o      (busy_t),
        .pix_count_o (pix_count_t)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Starts on a negedge in idle; ends on the negedge after completion.
    task automatic run_pix(input string tag, input logic [7:0] a, input logic [7:0] img,
                           input logic [7:0] wm, input logic [7:0] exp_r,
                           input logic [7:0] exp_t);
        chk({tag, ".in_ready"}, in_ready, 1);
        in_valid  = 1'b1;
        cfg_alpha = a;
        img_pix   = img;
        wm_pix    = wm;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        cfg_alpha = ~a;
        img_pix   = img ^ 8'h5a;
        wm_pix    = ~wm;
        chk({tag, ".busy1"}, busy, 1);
        chk({tag, ".in_ready1"}, in_ready, 0);
        chk({tag, ".out_valid1"}, out_valid, 0);
        @(negedge clk);
        chk({tag, ".out_valid2"}, out_valid, 0);
        @(negedge clk);
        chk({tag, ".out_valid3"}, out_valid, 1);
        chk({tag, ".out_valid3_t"}, out_valid_t, 1);
        chk({tag, ".pix_r"}, out_pix, exp_r);
        chk({tag, ".pix_t"}, out_pix_t, exp_t);
        chk({tag, ".cnt_hold"}, pix_count, exp_cnt);
        @(negedge clk);
        exp_cnt++;
        exp_cnt_t++;
        chk({tag, ".cnt"}, pix_count, exp_cnt);
        chk({tag, ".cnt_t"}, pix_count_t, exp_cnt_t);
        chk({tag, ".out_valid_done"}, out_valid, 0);
        chk({tag, ".busy_done"}, busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        img_pix   = 8'd0;
        wm_pix    = 8'd0;
        cfg_alpha = 8'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.busy", busy, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_pix", out_pix, 0);
        chk("rst.pix_count", pix_count, 0);
        rst = 1'b0;

        // First accept lands on the first rising edge after reset release.
        run_pix("a255", 8'd255, 8'd200, 8'd50, 8'd199, 8'd199);
        run_pix("a0", 8'd0, 8'd10, 8'd255, 8'd254, 8'd254);
        run_pix("a128", 8'd128, 8'd100, 8'd200, 8'd149, 8'd149);
        run_pix("round", 8'd255, 8'd1, 8'd77, 8'd1, 8'd0);
        run_pix("a100", 8'd100, 8'd50, 8'd150, 8'd110, 8'd110);
        run_pix("max", 8'd255, 8'd255, 8'd255, 8'd254, 8'd254);
        run_pix("a0img", 8'd0, 8'd255, 8'd0, 8'd0, 8'd0);

        // Output stall in HOLD with a competing in_valid.
        in_valid  = 1'b1;
        cfg_alpha = 8'd128;
        img_pix   = 8'd100;
        wm_pix    = 8'd200;
        out_ready = 1'b0;
        @(negedge clk);
        cfg_alpha = 8'd3;
        img_pix   = 8'd4;
        wm_pix    = 8'd5;
        @(negedge clk);
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            chk("stall.out_valid", out_valid, 1);
            chk("stall.out_pix", out_pix, 149);
            chk("stall.in_ready", in_ready, 0);
            chk("stall.cnt", pix_count, exp_cnt);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stall.still_hold", out_valid, 1);
        @(negedge clk);
        exp_cnt++;
        exp_cnt_t++;
        chk("stall.release_cnt", pix_count, exp_cnt);
        chk("stall.release_ov", out_valid, 0);

        // Reset while in MUL_WM discards the pixel.
        in_valid  = 1'b1;
        cfg_alpha = 8'd255;
        img_pix   = 8'd200;
        wm_pix    = 8'd50;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst.busy", busy, 0);
        chk("midrst.in_ready", in_ready, 1);
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.out_pix", out_pix, 0);
        chk("midrst.cnt", pix_count, 0);
        exp_cnt   = '0;
        exp_cnt_t = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("midrst.no_valid", out_valid, 0);
        end
        run_pix("after_rst", 8'd128, 8'd100, 8'd200, 8'd149, 8'd149);

        // Back-to-back with in_valid held high and inputs changing every cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("b2b.in_ready", in_ready, 32'(bb_rdy[i]));
            chk("b2b.out_valid", out_valid, 32'(bb_ov[i]));
            if (bb_ov[i]) begin
                chk("b2b.out_pix", out_pix, 32'(bb_px[i]));
                chk("b2b.out_pix_t", out_pix_t, 32'(bb_px[i]));
                exp_cnt++;
                exp_cnt_t++;
            end
            in_valid  = 1'b1;
            cfg_alpha = bb_a[i];
            img_pix   = bb_img[i];
            wm_pix    = bb_wm[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b.idle", busy, 0);
        chk("b2b.cnt", pix_count, exp_cnt);

        // Counter wrap.
        force dut.cnt_q = 16'hffff;
        @(negedge clk);
        release dut.cnt_q;
        exp_cnt = 16'hffff;
        chk("wrap.preload", pix_count, exp_cnt);
        run_pix("wrap", 8'd100, 8'd50, 8'd150, 8'd110, 8'd110);
        chk("wrap.zero", pix_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
